// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling ratio and the
// status-register bit positions used by the transmitter, receiver and regbank.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 3'd0;
    localparam uart_state_t ST_START = 3'd1;
    localparam uart_state_t ST_DATA  = 3'd2;
    localparam uart_state_t ST_STOP  = 3'd3;
    localparam uart_state_t ST_BREAK = 3'd4;

    localparam int unsigned OVERSAMPLE      = 16;
    localparam int unsigned HALF_OVERSAMPLE = OVERSAMPLE / 2;

    localparam int unsigned STAT_RDY = 0;
    localparam int unsigned STAT_OVR = 1;
    localparam int unsigned STAT_FRM = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one tick every i_div+1 clocks, restartable so that
// sampling can be phase-aligned to a start edge.
module uart_baud_tick #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_restart,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 w_wrap;

    assign w_wrap = (r_cnt == r_div);
    assign o_tick = w_wrap & ~i_restart;

    // The divisor is only picked up at a wrap or restart, so a mid-period change
    // can never leave the counter running past its terminal value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_div <= '0;
        end else if (i_restart || w_wrap) begin
            r_cnt <= '0;
            r_div <= i_div;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronises the rx line, oversamples each bit and drives the
// regbank uart_rx_data write port plus the ready/overrun/framing status bits.
module uart_rx #(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic                 i_ex_clk,
    input  logic                 i_ex_reset,
    input  logic                 i_rx_enable,
    input  logic [DIV_WIDTH-1:0] i_baud_div,
    input  logic                 i_rx_in,
    input  logic                 i_rd_ack,
    input  logic                 i_err_clr,
    output logic [7:0]           o_rx_data_out,
    output logic                 o_rx_data_en,
    output logic                 o_rx_ready,
    output logic                 o_overrun_err,
    output logic                 o_framing_err
);

    import uart_pkg::*;

    localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);

    logic        r_rx_meta;
    logic        r_rx_s;
    uart_state_t r_state;
    logic [3:0]  r_s_cnt;
    logic [2:0]  r_b_idx;
    logic [7:0]  r_shreg;
    logic        r_acc_pend;
    logic [7:0]  r_data;
    logic        r_data_en;
    logic [2:0]  r_status;

    uart_state_t w_state_nxt;
    logic [3:0]  w_s_cnt_nxt;
    logic [2:0]  w_b_idx_nxt;
    logic [7:0]  w_shreg_nxt;
    logic        w_stop_ok;
    logic        w_frm_set;
    logic        w_tick;
    logic        w_restart;

    always_ff @(posedge i_ex_clk) begin
        if (i_ex_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_restart = (r_state == ST_IDLE) & i_rx_enable & ~r_rx_s;

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .i_clk     (i_ex_clk),
        .i_reset   (i_ex_reset),
        .i_restart (w_restart),
        .i_div     (i_baud_div),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_s_cnt_nxt = r_s_cnt;
        w_b_idx_nxt = r_b_idx;
        w_shreg_nxt = r_shreg;
        w_stop_ok   = 1'b0;
        w_frm_set   = 1'b0;
        if (!i_rx_enable) begin
            w_state_nxt = ST_IDLE;
            w_s_cnt_nxt = '0;
            w_b_idx_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        w_state_nxt = ST_START;
                        w_s_cnt_nxt = '0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_s_cnt == S_MID) begin
                            // A line back high at mid start bit was only a glitch.
                            w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
                            w_s_cnt_nxt = '0;
                            w_b_idx_nxt = '0;
                        end else begin
                            w_s_cnt_nxt = r_s_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_s_cnt == S_LAST) begin
                            w_shreg_nxt[r_b_idx] = r_rx_s;
                            w_s_cnt_nxt          = '0;
                            w_b_idx_nxt          = r_b_idx + 1'b1;
                            if (r_b_idx == 3'd7) begin
                                w_state_nxt = ST_STOP;
                            end
                        end else begin
                            w_s_cnt_nxt = r_s_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_s_cnt == S_LAST) begin
                            w_s_cnt_nxt = '0;
                            w_stop_ok   = r_rx_s;
                            w_frm_set   = ~r_rx_s;
                            w_state_nxt = r_rx_s ? ST_IDLE : ST_BREAK;
                        end else begin
                            w_s_cnt_nxt = r_s_cnt + 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (r_rx_s) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_ex_clk) begin
        if (i_ex_reset) begin
            r_state <= ST_IDLE;
            r_s_cnt <= '0;
            r_b_idx <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s_cnt <= w_s_cnt_nxt;
            r_b_idx <= w_b_idx_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    // A completed byte is delivered the cycle after its stop sample; a coincident
    // rd_ack frees the holding register in time to take it.
    always_ff @(posedge i_ex_clk) begin
        if (i_ex_reset) begin
            r_acc_pend <= 1'b0;
            r_data     <= '0;
            r_data_en  <= 1'b0;
            r_status   <= '0;
        end else begin
            r_acc_pend <= w_stop_ok;
            r_data_en  <= 1'b0;
            if (r_acc_pend) begin
                if (!r_status[STAT_RDY] || i_rd_ack) begin
                    r_data             <= r_shreg;
                    r_data_en          <= 1'b1;
                    r_status[STAT_RDY] <= 1'b1;
                    if (i_rd_ack) begin
                        r_status[STAT_OVR] <= 1'b0;
                    end
                end else begin
                    r_status[STAT_OVR] <= 1'b1;
                end
            end else if (i_rd_ack) begin
                r_status[STAT_RDY] <= 1'b0;
                r_status[STAT_OVR] <= 1'b0;
            end
            if (w_frm_set) begin
                r_status[STAT_FRM] <= 1'b1;
            end else if (i_err_clr) begin
                r_status[STAT_FRM] <= 1'b0;
            end
        end
    end

    assign o_rx_data_out = r_data;
    assign o_rx_data_en  = r_data_en;
    assign o_rx_ready    = r_status[STAT_RDY];
    assign o_overrun_err = r_status[STAT_OVR];
    assign o_framing_err = r_status[STAT_FRM];

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// compared against a frame-level model of the receiver's status and data.
module tb_uart_rx;

    import uart_pkg::*;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        rx_enable = 1'b0;
    logic [15:0] baud_div  = 16'd3;
    logic        rx_in     = 1'b1;
    logic        rd_ack    = 1'b0;
    logic        err_clr   = 1'b0;
    logic [7:0]  rx_data_out;
    logic        rx_data_en;
    logic        rx_ready;
    logic        overrun_err;
    logic        framing_err;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int n_strobes = 0;
    int strobe_cyc = 0;
    int start_cyc  = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    logic [7:0] m_data    = 8'h00;
    logic       m_ready   = 1'b0;
    logic       m_ovr     = 1'b0;
    logic       m_frm     = 1'b0;
    int         m_strobes = 0;

    uart_rx #(
        .DIV_WIDTH  (16),
        .OVERSAMPLE (16)
    ) dut (
        .i_ex_clk      (clk),
        .i_ex_reset    (reset),
        .i_rx_enable   (rx_enable),
        .i_baud_div    (baud_div),
        .i_rx_in       (rx_in),
        .i_rd_ack      (rd_ack),
        .i_err_clr     (err_clr),
        .o_rx_data_out (rx_data_out),
        .o_rx_data_en  (rx_data_en),
        .o_rx_ready    (rx_ready),
        .o_overrun_err (overrun_err),
        .o_framing_err (framing_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rx_data_en === 1'b1) begin
            n_strobes  = n_strobes + 1;
            strobe_cyc = cyc;
            got_q.push_back(rx_data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int bit_clks();
        return 16 * (int'(baud_div) + 1);
    endfunction

    // Drives one frame; abort_bit in 0..7 drops rx_enable in the middle of that bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_bit);
        start_cyc = cyc;
        rx_in = 1'b0;
        wait_clks(bit_clks());
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            if (i == abort_bit) begin
                wait_clks(bit_clks() / 2);
                rx_enable = 1'b0;
                wait_clks(bit_clks() - bit_clks() / 2);
            end else begin
                wait_clks(bit_clks());
            end
        end
        rx_in = stop;
        wait_clks(bit_clks());
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        wait_clks(n * bit_clks());
    endtask

    function automatic void model_frame(input logic [7:0] b, input logic stop);
        if (!stop) begin
            m_frm = 1'b1;
        end else if (!m_ready) begin
            m_data = b;
            m_ready = 1'b1;
            m_strobes++;
            exp_q.push_back(b);
        end else begin
            m_ovr = 1'b1;
        end
    endfunction

    task automatic ack();
        rd_ack = 1'b1;
        wait_clks(1);
        rd_ack = 1'b0;
        m_ready = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic clr();
        err_clr = 1'b1;
        wait_clks(1);
        err_clr = 1'b0;
        m_frm = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"}, rx_data_out, m_data);
        check({tag, ".ready"}, rx_ready, m_ready);
        check({tag, ".ovr"}, overrun_err, m_ovr);
        check({tag, ".frm"}, framing_err, m_frm);
        check({tag, ".strobes"}, n_strobes, m_strobes);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, ".byte"}, got_q.pop_front(), exp_q.pop_front());
        end
        check({tag, ".leftover"}, got_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        int         lat;

        wait_clks(4);
        check("reset.data", rx_data_out, 8'h00);
        check("reset.flags", {rx_data_en, rx_ready, overrun_err, framing_err}, 4'b0000);
        check("reset.state", dut.r_state, ST_IDLE);
        reset = 1'b0;
        rx_enable = 1'b1;
        idle_bits(2);

        // Basic byte with latency window
        send_frame(8'hA5, 1'b1, -1);
        idle_bits(1);
        model_frame(8'hA5, 1'b1);
        check_all("basic");
        lat = strobe_cyc - start_cyc;
        check("basic.latency_in_611pm4", (lat >= 607 && lat <= 615), 1);

        ack();
        send_frame(8'h00, 1'b1, -1);
        model_frame(8'h00, 1'b1);
        ack();
        send_frame(8'hFF, 1'b1, -1);
        model_frame(8'hFF, 1'b1);
        idle_bits(1);
        check_all("b2b");

        ack();
        send_frame(8'h3C, 1'b1, -1);
        model_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1, -1);
        model_frame(8'hC3, 1'b1);
        idle_bits(1);
        check_all("overrun");
        ack();
        check_all("overrun_ack");

        send_frame(8'h55, 1'b0, -1);
        model_frame(8'h55, 1'b0);
        rx_in = 1'b0;
        wait_clks(30 * bit_clks());
        check_all("framing");
        check("framing.state", dut.r_state, ST_BREAK);
        idle_bits(2);
        check("break_exit.state", dut.r_state, ST_IDLE);
        send_frame(8'h12, 1'b1, -1);
        model_frame(8'h12, 1'b1);
        idle_bits(1);
        check_all("after_break");
        clr();
        check_all("err_clr");

        ack();
        rx_in = 1'b0;
        wait_clks(3 * (int'(baud_div) + 1));
        idle_bits(2);
        check_all("glitch");
        check("glitch.state", dut.r_state, ST_IDLE);

        send_frame(8'h81, 1'b1, 4);
        idle_bits(2);
        rx_enable = 1'b1;
        idle_bits(1);
        check_all("abort");
        check("abort.state", dut.r_state, ST_IDLE);
        send_frame(8'h81, 1'b1, -1);
        model_frame(8'h81, 1'b1);
        idle_bits(1);
        check_all("reenable");

        rx_in = 1'b0;
        wait_clks(2 * bit_clks());
        reset = 1'b1;
        rx_in = 1'b1;
        wait_clks(1);
        check("midreset.data", rx_data_out, 8'h00);
        check("midreset.flags", {rx_data_en, rx_ready, overrun_err, framing_err}, 4'b0000);
        check("midreset.state", dut.r_state, ST_IDLE);
        reset = 1'b0;
        m_data = 8'h00;
        m_ready = 1'b0;
        m_ovr = 1'b0;
        m_frm = 1'b0;
        idle_bits(12);
        check_all("midreset_quiet");

        for (int it = 0; it < 24; it++) begin
            baud_div = 16'($urandom_range(0, 3));
            idle_bits(1);
            if ($urandom_range(0, 1) == 1) ack();
            if ($urandom_range(0, 3) == 0) clr();
            b = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop, -1);
            model_frame(b, stop);
            if (!stop) begin
                rx_in = 1'b0;
                wait_clks($urandom_range(0, 3) * bit_clks());
            end
            idle_bits(1);
            check_all($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver (8N1, LSB first) on the controller's debug/console link.
- It is the receive counterpart of the UART transmit data path.
- Deserialises the rx pin into bytes and drives the regbank uart_rx_data write port (data plus one-cycle enable).
- Maintains the receive status bits that feed uart_ctrl_status.
- Sits beside the regbank in the datapath, clocked by ex_clk.

Parameters:
- DIV_WIDTH, 16, width of the baud divisor input.
- OVERSAMPLE, 16, sample ticks per bit period (fixed, power of two).

Ports:
- ex_clk  input  1  system clock; all logic on the rising edge.
- ex_reset  input  1  synchronous, active-high reset.
- rx_enable  input  1  receiver enable (uart_ctrl_status control bit); low aborts any frame in progress.
- baud_div  input  DIV_WIDTH  sample tick period minus one; one tick every baud_div+1 clocks.
- rx_in  input  1  asynchronous serial line; idle high.
- rd_ack  input  1  one-cycle pulse when the host reads uart_rx_data; clears rx_ready and overrun_err.
- err_clr  input  1  one-cycle pulse; clears framing_err.
- rx_data_out  output  8  last accepted byte (uart_rx_data_in).
- rx_data_en  output  1  one-cycle write strobe (uart_rx_data_en).
- rx_ready  output  1  unread byte held (status bit 0).
- overrun_err  output  1  byte lost because rx_ready was still set (status bit 1, sticky).
- framing_err  output  1  stop bit sampled low (status bit 2, sticky).

Behaviour:
- Reset values: rx_data_out=0x00; rx_data_en, rx_ready, overrun_err and framing_err all 0; FSM in IDLE; tick counter 0.
- Synchroniser: 2-flop on rx_in, with a reset value of 1. All decisions use the synchronised value rx_s, which adds 2 cycles of latency.
- Tick generator:
  - Counter runs 0..baud_div and pulses tick when it reaches baud_div, then returns to 0.
  - baud_div=0 gives a tick every clock.
  - Counter restarts at 0 on the IDLE→START transition, so sampling is phase-aligned to the start edge.
  - A baud_div change takes effect from the next counter wrap.
- FSM states: IDLE, START, DATA, STOP, BREAK. Each state has a tick counter s_cnt (4 bits) and a bit index b_idx (3 bits).
  - IDLE: rx_enable=1 and rx_s=0 → START, with s_cnt=0.
  - START: on the tick where s_cnt=7 (mid start bit), sample rx_s.
    - rx_s=1: glitch; return to IDLE with no status change.
    - rx_s=0: go to DATA with s_cnt=0 and b_idx=0.
  - DATA: on each tick where s_cnt=15, shift rx_s into shreg[b_idx] (LSB first).
    - After b_idx=7, go to STOP.
  - STOP: on the tick where s_cnt=15, sample rx_s.
    - rx_s=1: accept the byte; return to IDLE.
    - rx_s=0: set framing_err and discard the byte; go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents re-triggering on a held-low line.
- Accept, in the cycle after the STOP sample:
  - rx_ready=0, or rd_ack asserted in that cycle: load rx_data_out, pulse rx_data_en for 1 cycle, rx_ready=1.
  - Otherwise: overrun_err=1; rx_data_out, rx_ready and rx_data_en are unchanged, and the new byte is dropped.
- rd_ack with no accept: rx_ready=0 and overrun_err=0 on the next edge.
- rd_ack together with an accept: the new byte is loaded, rx_ready stays 1, and overrun_err is cleared.
- err_clr together with a new framing error: the set wins, framing_err=1.
- rx_enable=0 in any state: FSM goes to IDLE on the next edge and the partial frame is discarded. Status flags and rx_data_out are retained.
- ex_reset mid-frame: everything returns to reset values on the next edge. No strobe is generated.
- Latency: the rx_data_en pulse occurs (9.5×OVERSAMPLE)×(baud_div+1) + 3 clocks after the start edge arrives at rx_in, ±1 tick.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4, in a 3-bit type;
  - OVERSAMPLE and its half value, 8;
  - status bit indices: RDY=0, OVR=1, FRM=2. These are shared with the transmitter and the regbank status mapping.
- Sub-module uart_baud_tick (divisor counter, restart input, tick output). It is reusable by the transmitter.

Test Plan:
- Basic byte: baud_div=3, send 0xA5 at 64 clocks per bit → rx_data_out=0xA5, a single rx_data_en pulse, rx_ready=1, no errors. Strobe arrives 611±4 clocks after the start edge.
- Back-to-back bytes: send 0x00 then 0xFF with rd_ack between them → both are received in order, two strobes, overrun_err=0.
- Overrun: send 0x3C and 0xC3 with no rd_ack → rx_data_out=0x3C, overrun_err=1, one strobe only. Then rd_ack → rx_ready=0, overrun_err=0.
- Framing error and break: send 0x55 with the stop bit low, then hold rx low for 30 bit times → framing_err=1, no strobe, FSM stays in BREAK. Line returns high, then send 0x12 → 0x12 received. err_clr → framing_err=0.
- Glitch rejection: 3-tick low pulse on an idle line → no strobe, no flags, FSM back in IDLE.
- Abort and reset: drop rx_enable during bit 4 of 0x81 → no strobe. Re-enable and send 0x81 → received. Assert ex_reset mid-frame → all outputs 0 on the next edge.
